// File: rtl/decode_pkg.sv
// decode_pkg: shared widths, opcode map, format enum and decoded bundle type for the RV32I decode stage.
package decode_pkg;
  localparam int INSN_WIDTH = 32;
  localparam int XLEN = 32;
  localparam int PC_WIDTH = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_ADDR_WIDTH = $clog2(NUM_REGS);
  localparam logic [6:0] OPC_OP = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;
  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [XLEN-1:0] imm;
    fmt_e fmt;
    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;
    logic illegal;
  } decoded_insn_t;
endpackage

// File: rtl/insn_decoder.sv
// insn_decoder: combinational RV32I field split, format classification and immediate generation.
module insn_decoder
  import decode_pkg::*;
(
  input  logic [INSN_WIDTH-1:0] insn,
  input  logic [PC_WIDTH-1:0]   pc,
  output decoded_insn_t         dec
);
  logic [6:0] opc;
  fmt_e fmt;
  logic [31:0] imm32;
  always_comb begin
    opc = insn[6:0];
    fmt = opc == OPC_OP ? FMT_R :
          (opc == OPC_OP_IMM || opc == OPC_LOAD || opc == OPC_JALR || opc == OPC_SYSTEM) ? FMT_I :
          opc == OPC_STORE ? FMT_S :
          opc == OPC_BRANCH ? FMT_B :
          (opc == OPC_LUI || opc == OPC_AUIPC) ? FMT_U :
          opc == OPC_JAL ? FMT_J : FMT_ILL;
    imm32 = fmt == FMT_I ? {{20{insn[31]}}, insn[31:20]} :
            fmt == FMT_S ? {{20{insn[31]}}, insn[31:25], insn[11:7]} :
            fmt == FMT_B ? {{20{insn[31]}}, insn[7], insn[30:25], insn[11:8], 1'b0} :
            fmt == FMT_U ? {insn[31:12], 12'b0} :
            fmt == FMT_J ? {{12{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0} : 32'd0;
    dec = '0;
    dec.pc = pc;
    dec.opcode = opc;
    dec.funct3 = insn[14:12];
    dec.funct7 = insn[31:25];
    dec.rs1 = insn[19:15];
    dec.rs2 = insn[24:20];
    dec.rd = insn[11:7];
    // Widening a signed 32-bit value sign-extends U-type too when XLEN > 32.
    dec.imm = XLEN'($signed(imm32));
    dec.fmt = fmt;
    dec.uses_rs1 = fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
    dec.uses_rs2 = fmt inside {FMT_R, FMT_S, FMT_B};
    dec.writes_rd = fmt inside {FMT_R, FMT_I, FMT_U, FMT_J} && insn[11:7] != '0;
    dec.illegal = fmt == FMT_ILL;
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode with a one-entry skid buffer so in_ready comes from a flop.
module decode_stage
  import decode_pkg::*;
#(
  parameter int INSN_WIDTH = 32,
  parameter int XLEN = 32,
  parameter int PC_WIDTH = 32,
  parameter int NUM_REGS = 32,
  localparam int REG_ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INSN_WIDTH-1:0]     in_insn,
  input  logic [PC_WIDTH-1:0]       in_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PC_WIDTH-1:0]       out_pc,
  output logic [6:0]                out_opcode,
  output logic [2:0]                out_funct3,
  output logic [6:0]                out_funct7,
  output logic [REG_ADDR_WIDTH-1:0] out_rs1,
  output logic [REG_ADDR_WIDTH-1:0] out_rs2,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic [XLEN-1:0]           out_imm,
  output logic [2:0]                out_fmt,
  output logic                      out_uses_rs1,
  output logic                      out_uses_rs2,
  output logic                      out_writes_rd,
  output logic                      out_illegal
);
  decoded_insn_t dec, out_q, skid_q;
  logic skid_valid, accept, xfer;
  insn_decoder u_dec (.insn(in_insn), .pc(in_pc), .dec(dec));
  assign in_ready = !skid_valid;
  assign accept = in_valid && in_ready;
  assign xfer = out_valid && out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      skid_valid <= 1'b0;
      out_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || xfer) begin
      out_valid <= skid_valid || accept;
      skid_valid <= 1'b0;
      if (skid_valid) out_q <= skid_q;
      else if (accept) out_q <= dec;
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_q <= dec;
    end
  end
  assign out_pc = out_q.pc;
  assign out_opcode = out_q.opcode;
  assign out_funct3 = out_q.funct3;
  assign out_funct7 = out_q.funct7;
  assign out_rs1 = out_q.rs1;
  assign out_rs2 = out_q.rs2;
  assign out_rd = out_q.rd;
  assign out_imm = out_q.imm;
  assign out_fmt = out_q.fmt;
  assign out_uses_rs1 = out_q.uses_rs1;
  assign out_uses_rs2 = out_q.uses_rs2;
  assign out_writes_rd = out_q.writes_rd;
  assign out_illegal = out_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors with hand-computed decode results and handshake checks.
module tb_decode_stage;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_insn = '0, in_pc = '0;
  logic in_ready, out_valid, out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [6:0] out_opcode, out_funct7;
  logic [2:0] out_funct3, out_fmt;
  logic [4:0] out_rs1, out_rs2, out_rd;
  int n_cmp = 0, n_err = 0;
  decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_insn(in_insn), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_uses_rs1(out_uses_rs1), .out_uses_rs2(out_uses_rs2), .out_writes_rd(out_writes_rd),
    .out_illegal(out_illegal)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] insn, input logic [31:0] pc);
    in_valid = v;
    in_insn = insn;
    in_pc = pc;
  endtask
  logic [31:0] s_insn [4] = '{32'h0020A423, 32'hFE000EE3, 32'h123452B7, 32'h001000EF};
  logic [31:0] s_imm [4] = '{32'h8, 32'hFFFFFFFC, 32'h12345000, 32'h800};
  logic [2:0] s_fmt [4] = '{3'd2, 3'd3, 3'd4, 3'd5};
  logic [31:0] ill [2] = '{32'h00000000, 32'h0000007F};
  initial begin
    step();
    step();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_imm", out_imm, 0);
    check("rst_fmt", out_fmt, 0);
    out_ready = 1'b1;
    drive(1, 32'hFFF00093, 32'h100);
    step();
    drive(0, 0, 0);
    check("addi_valid", out_valid, 1);
    check("addi_fmt", out_fmt, 1);
    check("addi_rd", out_rd, 1);
    check("addi_rs1", out_rs1, 0);
    check("addi_imm", out_imm, 32'hFFFFFFFF);
    check("addi_wr", out_writes_rd, 1);
    check("addi_u1", out_uses_rs1, 1);
    check("addi_u2", out_uses_rs2, 0);
    check("addi_pc", out_pc, 32'h100);
    step();
    check("idle_valid", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, s_insn[i], 32'h200 + 32'(4 * i));
      step();
      check($sformatf("stream%0d_valid", i), out_valid, 1);
      check($sformatf("stream%0d_pc", i), out_pc, 32'h200 + 32'(4 * i));
      check($sformatf("stream%0d_fmt", i), out_fmt, s_fmt[i]);
      check($sformatf("stream%0d_imm", i), out_imm, s_imm[i]);
    end
    check("jal_rd", out_rd, 1);
    drive(0, 0, 0);
    step();
    out_ready = 1'b0;
    drive(1, 32'h0020A423, 32'h300);
    step();
    check("sw_rs1", out_rs1, 1);
    check("sw_rs2", out_rs2, 2);
    check("sw_wr", out_writes_rd, 0);
    check("bp_ready_a", in_ready, 1);
    drive(1, 32'h00100093, 32'h304);
    step();
    check("bp_ready_b", in_ready, 0);
    check("bp_hold_a", out_pc, 32'h300);
    drive(1, 32'h00200093, 32'h308);
    step();
    check("bp_ready_c", in_ready, 0);
    check("bp_still_a", out_pc, 32'h300);
    check("bp_still_fmt", out_fmt, 2);
    out_ready = 1'b1;
    step();
    check("bp_out_b", out_pc, 32'h304);
    check("bp_imm_b", out_imm, 1);
    check("bp_ready_after", in_ready, 1);
    step();
    drive(0, 0, 0);
    check("bp_out_c", out_pc, 32'h308);
    check("bp_imm_c", out_imm, 2);
    step();
    check("bp_drained", out_valid, 0);
    for (int i = 0; i < 2; i++) begin
      drive(1, ill[i], 32'h400 + 32'(4 * i));
      step();
      check($sformatf("ill%0d_valid", i), out_valid, 1);
      check($sformatf("ill%0d_fmt", i), out_fmt, 7);
      check($sformatf("ill%0d_flag", i), out_illegal, 1);
      check($sformatf("ill%0d_imm", i), out_imm, 0);
      check($sformatf("ill%0d_wr", i), out_writes_rd, 0);
    end
    drive(1, 32'h00208033, 32'h410);
    step();
    drive(0, 0, 0);
    check("add0_fmt", out_fmt, 0);
    check("add0_wr", out_writes_rd, 0);
    check("add0_u1", out_uses_rs1, 1);
    check("add0_u2", out_uses_rs2, 1);
    check("add0_ill", out_illegal, 0);
    check("add0_rs", {out_rs1, out_rs2}, {5'd1, 5'd2});
    step();
    out_ready = 1'b0;
    drive(1, 32'h00100093, 32'h500);
    step();
    drive(1, 32'h00200093, 32'h504);
    step();
    check("fl_full", in_ready, 0);
    drive(1, 32'h00300093, 32'h508);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(0, 0, 0);
    check("fl_valid", out_valid, 0);
    check("fl_ready", in_ready, 1);
    out_ready = 1'b1;
    drive(1, 32'h00400093, 32'h50C);
    step();
    drive(0, 0, 0);
    check("fl_next_valid", out_valid, 1);
    check("fl_next_pc", out_pc, 32'h50C);
    step();
    check("fl_no_leak", out_valid, 0);
    out_ready = 1'b0;
    drive(1, 32'h00100093, 32'h600);
    step();
    drive(1, 32'h00200093, 32'h604);
    step();
    drive(1, 32'h00300093, 32'h608);
    rst = 1'b1;
    flush = 1'b1;
    step();
    rst = 1'b0;
    flush = 1'b0;
    drive(0, 0, 0);
    check("mrst_valid", out_valid, 0);
    check("mrst_ready", in_ready, 1);
    check("mrst_pc", out_pc, 0);
    check("mrst_imm", out_imm, 0);
    check("mrst_fmt", out_fmt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipelined RV32I decode stage between fetch and issue/rename.
- Takes one fetched instruction word plus PC per handshake and splits it into fields.
- Generates the sign-extended immediate for every base format (I/S/B/U/J), classifies the format and flags illegal encodings.
- Registered output with a one-entry skid buffer, so in_ready is a register output and backpressure never drops an instruction.

Parameters:
INSN_WIDTH, 32, instruction word width
XLEN, 32, immediate/data width; immediate is sign-extended to XLEN
PC_WIDTH, 32, program counter width
NUM_REGS, 32, architectural register count; REG_ADDR_WIDTH = $clog2(NUM_REGS)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
flush  input  1  discard all held instructions (branch mispredict/exception)
in_valid  input  1  fetch presents an instruction
in_ready  output  1  stage can accept; registered
in_insn  input  INSN_WIDTH  instruction word
in_pc  input  PC_WIDTH  PC of in_insn
out_valid  output  1  decoded bundle valid
out_ready  input  1  downstream accepts bundle
out_pc  output  PC_WIDTH  PC of the decoded instruction
out_opcode  output  7  insn[6:0]
out_funct3  output  3  insn[14:12]
out_funct7  output  7  insn[31:25]
out_rs1  output  REG_ADDR_WIDTH  insn[19:15]
out_rs2  output  REG_ADDR_WIDTH  insn[24:20]
out_rd  output  REG_ADDR_WIDTH  insn[11:7]
out_imm  output  XLEN  sign-extended immediate
out_fmt  output  3  fmt_e: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7
out_uses_rs1  output  1  instruction reads rs1
out_uses_rs2  output  1  instruction reads rs2
out_writes_rd  output  1  instruction writes rd; forced 0 when rd==0
out_illegal  output  1  unrecognised opcode or insn[1:0]!=2'b11

Behaviour:
- Clocking: one clock (clk); rst is synchronous and active-high.
- Reset: out_valid=0, skid_valid=0, in_ready=1. All payload outputs reset to 0; out_fmt resets to R.
- Decode is combinational on in_insn and is captured into the output register or the skid register on accept. Latency is 1 cycle from accept (in_valid&&in_ready) to out_valid.
- Opcode map:
  - 0110011 -> R (rs1, rs2, rd)
  - 0010011, 0000011, 1100111, 1110011 -> I (rs1, rd)
  - 0100011 -> S (rs1, rs2)
  - 1100011 -> B (rs1, rs2)
  - 0110111, 0010111 -> U (rd)
  - 1101111 -> J (rd)
  - Anything else -> ILL: illegal=1, imm=0, all uses/writes=0. The bundle still flows so the backend can raise the exception.
- Immediates:
  - I: sext(insn[31:20])
  - S: sext({insn[31:25],insn[11:7]})
  - B: sext({insn[31],insn[7],insn[30:25],insn[11:8],1'b0})
  - U: {insn[31:12],12'b0}, sign-extended when XLEN>32
  - J: sext({insn[31],insn[19:12],insn[20],insn[30:21],1'b0})
  - R: imm=0
- Handshake:
  - An output transfer occurs when out_valid&&out_ready.
  - in_ready = !skid_valid.
  - On accept:
    - If the output register is empty or transferring this cycle and the skid is empty, the decoded input goes to the output register.
    - Otherwise (output held, not transferring), it goes to the skid register.
  - When the output transfers and the skid is valid, the skid moves to the output register and skid_valid clears. A same-cycle accept then cannot occur, because in_ready was 0.
  - Output payload is stable while out_valid&&!out_ready.
- Throughput: 1 instruction/cycle with out_ready held high. No bubbles are inserted.
- flush: on the next edge out_valid=0 and skid_valid=0; any same-cycle input is discarded. flush has priority over accept and transfer. A simultaneous downstream transfer is still considered completed by the consumer.
- rst overrides flush.

Decomposition:
- Package decode_pkg holds:
  - fmt_e enum
  - opcode localparams (OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL)
  - packed struct decoded_insn_t (all out_* payload fields)
- Sub-module insn_decoder: purely combinational, insn -> decoded_insn_t.
- decode_stage holds the handshake, output register and skid register.

Test Plan:
- Reset then idle: in_ready=1, out_valid=0. addi x1,x0,-1 (0xFFF00093) with out_ready=1 -> next cycle out_valid=1, fmt=I, rd=1, rs1=0, imm=0xFFFFFFFF, writes_rd=1, uses_rs2=0.
- Back-to-back streaming, out_ready=1:
  - sw x2,8(x1) (0x0020A423) -> fmt=S, rs1=1, rs2=2, imm=8, writes_rd=0
  - beq x0,x0,-4 (0xFE000EE3) -> fmt=B, imm=0xFFFFFFFC
  - lui x5,0x12345 (0x123452B7) -> fmt=U, imm=0x12345000
  - jal x1,2048 (0x001000EF) -> fmt=J, imm=0x800
  - All four bundles arrive on consecutive cycles with their PCs preserved.
- Backpressure: stream 3 instructions with out_ready=0. First goes to output, second to skid, in_ready drops to 0, third is held at the input. Raise out_ready -> the bundles emerge in order with no loss or duplication.
- Illegal encodings: 0x00000000 and 0x0000007F -> fmt=ILL, illegal=1, imm=0, writes_rd=0, out_valid=1.
- rd==0 suppression: add x0,x1,x2 (0x00208033) -> fmt=R, writes_rd=0, uses_rs1=uses_rs2=1.
- Flush with both output and skid full plus a new in_valid -> next cycle out_valid=0 and in_ready=1; the next accepted instruction appears with 1-cycle latency. Repeat with rst asserted mid-stream -> reset values are reached on the next edge.
